uart_tx_arb: RTL
================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, which is the number of idle cycles allowed between bytes of a granted packet.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-003 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports i_req0_byte and i_req1_byte, input, 8 bits each: requester data bytes.
REQ-005 SHALL have ports i_req0_valid and i_req1_valid, input, 1 bit each: the requester's byte is valid.
REQ-006 SHALL have ports i_req0_last and i_req1_last, input, 1 bit each: this byte is the last byte of the packet.
REQ-007 SHALL have ports o_req0_ready and o_req1_ready, output, 1 bit each: the requester's byte is accepted this cycle.
REQ-008 SHALL have port o_tx_byte, output, 8 bits: byte to uart_tx.
REQ-009 SHALL have port o_tx_byte_valid, output, 1 bit: single-cycle start pulse to uart_tx.
REQ-010 SHALL have port i_tx_busy, input, 1 bit: uart_tx is serializing a byte.
REQ-011 SHALL have port o_grant, output, 2 bits: one-hot current owner, 00 when no packet is locked.
REQ-012 SHALL have port o_timeout, output, 1 bit: one-cycle pulse when a packet is aborted.

Function
REQ-013 SHALL implement the states IDLE, SEND, WAIT_START and WAIT_DONE; any illegal encoding SHALL return to IDLE.
REQ-014 In IDLE, when one or more req valid signals are high, the block SHALL register a one-hot grant and move to SEND on the next edge.
REQ-015 The grant SHALL be round-robin: when both requesters are valid, the one not granted last wins; after reset, req0 wins a tie.
REQ-016 The grant SHALL stay locked for the whole packet, until the last byte has completed or a timeout occurs.
REQ-017 o_reqN_ready SHALL be combinational and high only when state==SEND, o_grant[N]==1 and i_tx_busy==0.
REQ-018 A transfer occurs on a cycle where valid and ready are both high; the non-granted ready SHALL be 0.
REQ-019 On a transfer, o_tx_byte SHALL register the byte, o_tx_byte_valid SHALL be 1 for exactly the next cycle, the last flag SHALL be latched, and the state SHALL move to WAIT_START.
REQ-020 In WAIT_START, the block SHALL move to WAIT_DONE on the first cycle i_tx_busy==1.
REQ-021 In WAIT_DONE, when i_tx_busy==0: if the latched last flag is 1, the block SHALL go to IDLE, clear o_grant and record the owner as last-granted; otherwise it SHALL go to SEND.
REQ-022 o_tx_byte SHALL hold its value until the next transfer.
REQ-023 o_tx_byte_valid SHALL never be high on two consecutive cycles.
REQ-024 A timeout counter SHALL count cycles in SEND in which the granted valid is 0, and SHALL clear on every transfer and on entry to SEND.
REQ-025 When the timeout counter reaches TIMEOUT-1 while the granted valid is still 0, the block SHALL go to IDLE on the next edge, pulse o_timeout for 1 cycle, clear o_grant, and record the aborted owner as last-granted.
REQ-026 A single-byte packet (last=1 on its first byte) SHALL release the grant after one WAIT_DONE.
REQ-027 The non-granted requester's valid SHALL be ignored until the state returns to IDLE; its byte is not consumed.
REQ-028 A valid that drops mid-packet SHALL NOT release the grant; only last or timeout releases it.
REQ-029 i_tx_busy already high on entry to SEND SHALL hold ready at 0 until it falls.
REQ-030 No datapath byte SHALL be dropped or duplicated: each valid&ready cycle produces exactly one o_tx_byte_valid pulse.

Reset
REQ-031 While i_rst==1 at a clock edge, the block SHALL set state=IDLE, o_tx_byte=8'h00, o_tx_byte_valid=0, o_grant=2'b00, o_timeout=0, last-granted=req1 (so req0 wins first), and clear the counter and latched last.
REQ-032 Reset asserted mid-packet SHALL abort with no further o_tx_byte_valid pulses; ready SHALL be 0 during reset.

Verification
REQ-033 Single packet: req0 sends 5A,11,22 with last on 22, busy high for 3 cycles after each pulse -> exactly three pulses with bytes 5A,11,22, o_grant=01 throughout, then 00.
REQ-034 Contention: both requesters valid from reset with 2-byte packets -> req0 bytes first, then req1; a repeat contention grants req1 first.
REQ-035 Lock: req1 becomes valid mid-packet of req0 -> o_req1_ready stays 0 and no req1 byte appears until req0's last byte completes.
REQ-036 Timeout with TIMEOUT=8: req0 sends one non-last byte, then valid=0 -> o_timeout pulses once, o_grant returns to 00, and req1 is granted next if valid.
REQ-037 Reset mid-packet: assert i_rst during WAIT_DONE of byte 2 of 4 -> all outputs are 0 the next cycle and there are no further pulses; after release, a tie grants req0.
REQ-038 Busy stall: i_tx_busy held high in SEND for 20 cycles -> ready is 0 and no pulse is issued; the byte transfers on the first cycle busy is low.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Two-requester arbiter in front of one uart_tx. It locks a round-robin grant for each packet and releases it on the last byte or on an idle timeout.
// Latency: the grant comes one cycle after valid, and o_tx_byte_valid one cycle after valid&ready. Ready stays low while uart_tx is busy or a byte is in flight.
module uart_tx_arb #(
    parameter int TIMEOUT = 1024
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_req0_byte,
    input  logic       i_req0_valid,
    input  logic       i_req0_last,
    output logic       o_req0_ready,
    input  logic [7:0] i_req1_byte,
    input  logic       i_req1_valid,
    input  logic       i_req1_last,
    output logic       o_req1_ready,
    output logic [7:0] o_tx_byte,
    output logic       o_tx_byte_valid,
    input  logic       i_tx_busy,
    output logic [1:0] o_grant,
    output logic       o_timeout
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_START, WAIT_DONE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    grant, grant_nxt;
    logic          last_gnt, last_gnt_nxt;   // 1 when req1 held the most recent grant
    logic          last_lat, last_lat_nxt;
    logic [CW-1:0] to_cnt, to_cnt_nxt;
    logic [7:0]    tx_byte, tx_byte_nxt;
    logic          tx_vld, tx_vld_nxt;
    logic          to_pulse, to_pulse_nxt;

    logic          send_ok, gnt_vld, gnt_last, xfer;
    logic [7:0]    gnt_byte;

    assign send_ok      = (state == SEND) && !i_tx_busy && !i_rst;
    assign o_req0_ready = send_ok && grant[0];
    assign o_req1_ready = send_ok && grant[1];
    assign gnt_vld      = (grant[0] && i_req0_valid) || (grant[1] && i_req1_valid);
    assign gnt_byte     = grant[1] ? i_req1_byte : i_req0_byte;
    assign gnt_last     = grant[1] ? i_req1_last : i_req0_last;
    assign xfer         = (o_req0_ready && i_req0_valid) || (o_req1_ready && i_req1_valid);

    assign o_tx_byte       = tx_byte;
    assign o_tx_byte_valid = tx_vld;
    assign o_grant         = grant;
    assign o_timeout       = to_pulse;

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        last_gnt_nxt = last_gnt;
        last_lat_nxt = last_lat;
        to_cnt_nxt   = to_cnt;
        tx_byte_nxt  = tx_byte;
        tx_vld_nxt   = 1'b0;
        to_pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (i_req0_valid || i_req1_valid) begin
                    if (i_req0_valid && (!i_req1_valid || last_gnt)) grant_nxt = 2'b01;
                    else                                              grant_nxt = 2'b10;
                    to_cnt_nxt = '0;
                    state_nxt  = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    tx_byte_nxt  = gnt_byte;
                    tx_vld_nxt   = 1'b1;
                    last_lat_nxt = gnt_last;
                    to_cnt_nxt   = '0;
                    state_nxt    = WAIT_START;
                end else if (!gnt_vld) begin
                    // A stalled-but-valid owner (busy high) never ages toward the abort.
                    if (to_cnt == TO_LAST) begin
                        to_pulse_nxt = 1'b1;
                        grant_nxt    = 2'b00;
                        last_gnt_nxt = grant[1];
                        state_nxt    = IDLE;
                    end else begin
                        to_cnt_nxt = to_cnt + CW'(1);
                    end
                end
            end
            WAIT_START: begin
                if (i_tx_busy) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    if (last_lat) begin
                        grant_nxt    = 2'b00;
                        last_gnt_nxt = grant[1];
                        state_nxt    = IDLE;
                    end else begin
                        to_cnt_nxt = '0;
                        state_nxt  = SEND;
                    end
                end
            end
            default: begin
                grant_nxt = 2'b00;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            grant    <= 2'b00;
            last_gnt <= 1'b1;
            last_lat <= 1'b0;
            to_cnt   <= '0;
            tx_byte  <= 8'h00;
            tx_vld   <= 1'b0;
            to_pulse <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            last_gnt <= last_gnt_nxt;
            last_lat <= last_lat_nxt;
            to_cnt   <= to_cnt_nxt;
            tx_byte  <= tx_byte_nxt;
            tx_vld   <= tx_vld_nxt;
            to_pulse <= to_pulse_nxt;
        end
    end
endmodule
